// File: rtl/spi_reg_sequencer.sv
// Avalon master that runs two-byte register transactions on the SPI master core.
// Optional poll timeout: define SPI_SEQ_TIMEOUT_EN (limit set by POLL_LIMIT).
//
// state     | meaning
// IDLE      | waiting for a request
// CLR_ST    | write status (addr 2) to clear stale error flags
// SET_SS    | write slaveselect (addr 5) = 0x0001
// SET_SSO   | write control (addr 3) = 0x0400, SS_n forced low
// TX_CMD    | write txdata (addr 1) = command byte
// POLL_CMD  | read status until RRDY
// RD_CMD    | read rxdata (addr 0) into status byte
// TX_DAT    | write txdata = data byte
// POLL_DAT  | read status until RRDY
// RD_DAT    | read rxdata into read-data byte
// CLR_SSO   | write control = 0x0000, SS_n released
// RESP      | rsp_valid pulse
module spi_reg_sequencer
`ifdef SPI_SEQ_TIMEOUT_EN
  #(parameter logic [7:0] POLL_LIMIT = 8'd255)
`endif
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [4:0]  req_reg_i,
  input  logic [7:0]  req_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_status_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        spi_select_o,
  output logic [2:0]  mem_addr_o,
  output logic        read_n_o,
  output logic        write_n_o,
  output logic [15:0] data_from_cpu_o,
  input  logic [15:0] data_to_cpu_i
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR_ST, S_SET_SS, S_SET_SSO, S_TX_CMD, S_POLL_CMD, S_RD_CMD,
    S_TX_DAT, S_POLL_DAT, S_RD_DAT, S_CLR_SSO, S_RESP
  } state_t;

  state_t      state_q, next_d, acc_state_d;
  logic [1:0]  ph_q;
  logic [7:0]  cmd_q, dat_q, status_q, rdata_q;
  logic        rrdy_q, timeout_d;
  logic [19:0] acc_d;
  logic        spi_select_q, read_n_q, write_n_q, rsp_valid_q;
  logic [2:0]  mem_addr_q;
  logic [15:0] data_q;
  logic [7:0]  rsp_status_q, rsp_rdata_q;
  logic        unused_rdata_hi;

  assign unused_rdata_hi = ^data_to_cpu_i[15:8];

  // Access descriptor: {is_write, address, write data}
  function automatic logic [19:0] access_of(input state_t s, input logic [7:0] cmd,
                                            input logic [7:0] dat);
    case (s)
      S_CLR_ST:               access_of = {1'b1, 3'd2, 16'h0000};
      S_SET_SS:               access_of = {1'b1, 3'd5, 16'h0001};
      S_SET_SSO:              access_of = {1'b1, 3'd3, 16'h0400};
      S_TX_CMD:               access_of = {1'b1, 3'd1, 8'h00, cmd};
      S_TX_DAT:               access_of = {1'b1, 3'd1, 8'h00, dat};
      S_POLL_CMD, S_POLL_DAT: access_of = {1'b0, 3'd2, 16'h0000};
      S_RD_CMD, S_RD_DAT:     access_of = {1'b0, 3'd0, 16'h0000};
      S_CLR_SSO:              access_of = {1'b1, 3'd3, 16'h0000};
      default:                access_of = 20'h0;
    endcase
  endfunction

`ifdef SPI_SEQ_TIMEOUT_EN
  logic [7:0] poll_cnt_q;
  logic       err_q, rsp_err_q;
  assign timeout_d = (poll_cnt_q == POLL_LIMIT);
  assign rsp_err_o = rsp_err_q;
`else
  assign timeout_d = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

  always_comb begin
    next_d = S_IDLE;
    case (state_q)
      S_CLR_ST:   next_d = S_SET_SS;
      S_SET_SS:   next_d = S_SET_SSO;
      S_SET_SSO:  next_d = S_TX_CMD;
      S_TX_CMD:   next_d = S_POLL_CMD;
      S_POLL_CMD: next_d = rrdy_q ? S_RD_CMD : (timeout_d ? S_CLR_SSO : S_POLL_CMD);
      S_RD_CMD:   next_d = S_TX_DAT;
      S_TX_DAT:   next_d = S_POLL_DAT;
      S_POLL_DAT: next_d = rrdy_q ? S_RD_DAT : (timeout_d ? S_CLR_SSO : S_POLL_DAT);
      S_RD_DAT:   next_d = S_CLR_SSO;
      S_CLR_SSO:  next_d = S_RESP;
      default:    next_d = S_IDLE;
    endcase
    acc_state_d = (state_q == S_IDLE) ? S_CLR_ST : next_d;
    acc_d = access_of(acc_state_d, cmd_q, dat_q);
  end

  // Each access: ph 0 and 1 strobe low, ph 2 bus idle with address/data held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      ph_q         <= 2'd0;
      cmd_q        <= 8'h00;
      dat_q        <= 8'h00;
      status_q     <= 8'h00;
      rdata_q      <= 8'h00;
      rrdy_q       <= 1'b0;
      spi_select_q <= 1'b0;
      read_n_q     <= 1'b1;
      write_n_q    <= 1'b1;
      mem_addr_q   <= 3'd0;
      data_q       <= 16'h0000;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 8'h00;
      rsp_rdata_q  <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
      poll_cnt_q   <= 8'd0;
      err_q        <= 1'b0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            cmd_q        <= {req_reg_i, 1'b0, req_write_i, 1'b0};
            dat_q        <= req_write_i ? req_wdata_i : 8'h00;
            status_q     <= 8'h00;
            rdata_q      <= 8'h00;
`ifdef SPI_SEQ_TIMEOUT_EN
            err_q        <= 1'b0;
`endif
            state_q      <= S_CLR_ST;
            ph_q         <= 2'd0;
            spi_select_q <= 1'b1;
            write_n_q    <= ~acc_d[19];
            read_n_q     <= acc_d[19];
            mem_addr_q   <= acc_d[18:16];
            data_q       <= acc_d[15:0];
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: begin
          case (ph_q)
            2'd0: ph_q <= 2'd1;
            2'd1: begin
              ph_q         <= 2'd2;
              spi_select_q <= 1'b0;
              read_n_q     <= 1'b1;
              write_n_q    <= 1'b1;
              if (state_q == S_POLL_CMD || state_q == S_POLL_DAT) begin
                rrdy_q <= data_to_cpu_i[7];
`ifdef SPI_SEQ_TIMEOUT_EN
                if (!data_to_cpu_i[7]) poll_cnt_q <= poll_cnt_q + 8'd1;
`endif
              end
              if (state_q == S_RD_CMD) status_q <= data_to_cpu_i[7:0];
              if (state_q == S_RD_DAT) rdata_q <= data_to_cpu_i[7:0];
            end
            default: begin
              ph_q    <= 2'd0;
              state_q <= next_d;
              if (next_d == S_RESP) begin
                rsp_valid_q  <= 1'b1;
                rsp_status_q <= status_q;
                rsp_rdata_q  <= rdata_q;
`ifdef SPI_SEQ_TIMEOUT_EN
                rsp_err_q    <= err_q;
`endif
              end else begin
                spi_select_q <= 1'b1;
                write_n_q    <= ~acc_d[19];
                read_n_q     <= acc_d[19];
                mem_addr_q   <= acc_d[18:16];
                data_q       <= acc_d[15:0];
              end
`ifdef SPI_SEQ_TIMEOUT_EN
              if ((next_d == S_POLL_CMD || next_d == S_POLL_DAT) && next_d != state_q)
                poll_cnt_q <= 8'd0;
              if (next_d == S_CLR_SSO && (state_q == S_POLL_CMD || state_q == S_POLL_DAT))
                err_q <= 1'b1;
`endif
            end
          endcase
        end
      endcase
    end
  end

  assign req_ready_o     = (state_q == S_IDLE);
  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_status_o    = rsp_status_q;
  assign rsp_rdata_o     = rsp_rdata_q;
  assign spi_select_o    = spi_select_q;
  assign mem_addr_o      = mem_addr_q;
  assign read_n_o        = read_n_q;
  assign write_n_o       = write_n_q;
  assign data_from_cpu_o = data_q;

endmodule

// File: doc/spi_reg_sequencer.md
# spi_reg_sequencer

Hardware Avalon master that sits directly upstream of the SPI master core's control port and replaces CPU polling for two-byte register transactions with SPI peripherals such as the USB host controller. It accepts a register read/write request, drives the SPI core's register map through write-data, status, control and slave-select accesses, and returns the received bytes with a single-cycle response pulse.

## Interface
- POLL_LIMIT, 255: maximum status polls per byte before timeout; only used with the timeout feature compiled in.
- clk  in  1  system clock, same as the SPI core's clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid & req_ready.
- req_write  in  1  1 = register write, 0 = register read.
- req_reg  in  5  peripheral register number.
- req_wdata  in  8  write data; ignored on reads.
- rsp_valid  out  1  one-cycle pulse when the transaction completes.
- rsp_status  out  8  byte received during the command byte.
- rsp_rdata  out  8  byte received during the data byte.
- rsp_err  out  1  timeout flag, valid with rsp_valid.
- spi_select  out  1  chip select to the SPI core.
- mem_addr  out  3  SPI core register address.
- read_n, write_n  out  1 each  active-low strobes.
- data_from_cpu  out  16  write data to the SPI core.
- data_to_cpu  in  16  registered read data from the SPI core.

## Operation
- Command byte is {req_reg, 1'b0, req_write, 1'b0}. The data byte is req_wdata on writes and 0x00 on reads.
- The request is latched on acceptance.
- The FSM steps through the states in this order:
  - CLR_ST: write addr 2, any data (clears stale status).
  - SET_SS: write addr 5 = 0x0001.
  - SET_SSO: write addr 3 = 0x0400 (forces SS_n low).
  - TX_CMD: write addr 1 = command byte.
  - POLL_CMD: read addr 2; repeat until bit 7 (RRDY) = 1.
  - RD_CMD: read addr 0; bits [7:0] go to rsp_status.
  - TX_DAT: write addr 1 = data byte.
  - POLL_DAT: read addr 2; repeat until bit 7 (RRDY) = 1.
  - RD_DAT: read addr 0; bits [7:0] go to rsp_rdata.
  - CLR_SSO: write addr 3 = 0x0000.
  - RESP: pulse rsp_valid, then return to IDLE.
- Reading every byte before sending the next one means ROE/TOE can never set in normal operation.
- Bus access unit:
  - spi_select = 1 and exactly one strobe low for exactly 2 cycles.
  - mem_addr and data_from_cpu stay stable for both cycles.
  - This is followed by exactly 1 idle cycle with spi_select = 0, read_n = write_n = 1 and mem_addr/data held.
- Read data is sampled from data_to_cpu on the rising edge that ends the 2nd strobe cycle.
- A strobe is never held for 3 or more cycles, because the SPI core would re-trigger the access.
- rsp_status, rsp_rdata and rsp_err hold their values until the next RESP.
- req_valid while busy is ignored; there is no queueing.

## Timing
- Every access takes 3 cycles.
- Transaction length is 3 × (10 + P_cmd + P_dat) + 1 cycles, counted from the acceptance edge to the rsp_valid cycle. P_cmd and P_dat are the numbers of polls that returned RRDY = 0.
- req_ready falls in the cycle after acceptance and rises in the cycle after rsp_valid.
- Reset values:
  - spi_select = 0, read_n = 1, write_n = 1, mem_addr = 0, data_from_cpu = 0.
  - rsp_valid = 0, rsp_status = 0, rsp_rdata = 0, rsp_err = 0.
  - FSM in IDLE, so req_ready = 1.
- Reset mid-transaction: the FSM returns to IDLE immediately and the bus is released that cycle; no response is produced. SS_n cleanup is the SPI core's own reset.

## Configuration
- SPI_SEQ_TIMEOUT_EN defined:
  - An 8-bit poll counter cleared on entry to each POLL state.
  - When POLL_LIMIT polls have all returned RRDY = 0, the FSM jumps to CLR_SSO.
  - RESP then shows rsp_err = 1, rsp_rdata = 0x00 and rsp_status as captured so far (0x00 if the command byte never completed).
- SPI_SEQ_TIMEOUT_EN undefined:
  - Polling is unbounded, the counter is removed and rsp_err is tied 0.

## Test plan
- Write req_reg = 17, req_wdata = 0x55, with an SPI core model plus a loopback slave returning 0xA0, 0x00 -> MOSI sends 0x8A then 0x55; rsp_status = 0xA0, rsp_err = 0, SS_n low for both bytes and high afterwards.
- Read req_reg = 18 with the slave returning 0x0C, 0xA5 -> command byte 0x90, data byte 0x00; rsp_status = 0x0C, rsp_rdata = 0xA5.
- Bus protocol monitor over 50 random transactions:
  - every strobe low for exactly 2 cycles, each followed by 1 idle cycle;
  - addresses appear in the order 2, 5, 3, 1, 2…, 0, 1, 2…, 0, 3;
  - the SPI core never sets TOE or ROE.
- SPI_SEQ_TIMEOUT_EN, POLL_LIMIT = 4, status model stuck at RRDY = 0 -> exactly 4 addr-2 reads per byte, then an addr 3 = 0x0000 write; rsp_valid with rsp_err = 1 and rsp_rdata = 0x00.
- req_valid held high during a transaction -> exactly one acceptance per rsp_valid.
- reset_n pulsed low during POLL_DAT -> bus outputs return to their reset values asynchronously; after release, req_ready = 1 and the next request completes correctly.
